// File: rtl/p5_writeback_pkg.sv
// Shared constants for the p5 writeback stage: IR field encodings, phase codes,
// FSM state encoding, write-data source select and flag bit positions.
package p5_writeback_pkg;

  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_ST  = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ALU = 2'b11;

  localparam logic [3:0] OP3_CMP = 4'b0101;
  localparam logic [3:0] OP3_IN  = 4'b1100;
  localparam logic [3:0] OP3_OUT = 4'b1101;
  localparam logic [3:0] OP3_HLT = 4'b1111;

  localparam logic [2:0] LI_SUB = 3'b000;

  localparam logic [2:0] PH_FETCH  = 3'b000;
  localparam logic [2:0] PH_DECODE = 3'b001;
  localparam logic [2:0] PH_EXEC   = 3'b010;
  localparam logic [2:0] PH_MEM    = 3'b011;
  localparam logic [2:0] PH_WB     = 3'b100;

  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURE  = 2'd1,
    ST_WAIT_MEM = 2'd2,
    ST_COMMIT   = 2'd3
  } wb_state_t;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_IO  = 2'd1,
    SRC_MEM = 2'd2
  } src_sel_t;

endpackage

// File: rtl/p5_wb_classify.sv
// Combinational IR decode for writeback: whether the instruction writes a register,
// which IR field names the target, where the data comes from, and flag/load behaviour.
module p5_wb_classify
  import p5_writeback_pkg::*;
(
  input  logic [15:0] ir,
  output logic        writes,
  output logic        addr_sel,
  output src_sel_t    src_sel,
  output logic        updates_flags,
  output logic        is_load
);

  logic [1:0] op;
  logic [3:0] op3;
  logic       unused_ir;

  assign op        = ir[15:14];
  assign op3       = ir[7:4];
  assign unused_ir = ^{ir[10:8], ir[3:0]};

  always_comb begin
    writes        = 1'b0;
    addr_sel      = 1'b0;
    src_sel       = SRC_ALU;
    updates_flags = 1'b0;
    is_load       = 1'b0;
    unique case (op)
      OP_ALU: begin
        case (op3)
          4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110,
          4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
            writes        = 1'b1;
            updates_flags = 1'b1;
          end
          OP3_CMP: updates_flags = 1'b1;
          OP3_IN: begin
            writes  = 1'b1;
            src_sel = SRC_IO;
          end
          default: ;
        endcase
      end
      OP_LD: begin
        writes   = 1'b1;
        addr_sel = 1'b1;
        src_sel  = SRC_MEM;
        is_load  = 1'b1;
      end
      OP_ST: ;
      OP_BR: writes = (ir[13:11] == LI_SUB);
      default: ;
    endcase
  end

endmodule

// File: rtl/p5_writeback.sv
// Writeback stage of the five-phase SIMPLE CPU: captures results in phase 011, waits for
// load data, drives the register-file write port in phase 100 and owns the S/Z/C/V flags.
// Optional retired-instruction counter enabled by defining WB_RETIRE_COUNT_EN.
module p5_writeback
  import p5_writeback_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        phase_counter,
  input  logic [15:0]       instruction_register_wire,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] io_in,
  output logic              op_reg_write,
  output logic              op_reg_write_address,
  output logic [DATA_W-1:0] data_for_write,
  output logic [3:0]        flags,
  output logic              phase_stall,
  output logic [CNT_W-1:0]  retired_count
);

  wb_state_t   state, next_state;
  logic        cls_writes, cls_addr_sel, cls_updates_flags, cls_is_load;
  src_sel_t    cls_src_sel;
  logic        wr_lat, upd_lat, load_lat;
  logic [3:0]  flags_cand;
  logic        phase_was_wb;
  logic        in_mem_or_wb, capture_en, load_take, commit_exit;
  logic [DATA_W-1:0] capture_data;

  p5_wb_classify u_classify (
    .ir            (instruction_register_wire),
    .writes        (cls_writes),
    .addr_sel      (cls_addr_sel),
    .src_sel       (cls_src_sel),
    .updates_flags (cls_updates_flags),
    .is_load       (cls_is_load)
  );

  assign in_mem_or_wb = (phase_counter == PH_MEM) || (phase_counter == PH_WB);
  assign capture_en   = (state == ST_IDLE) && (phase_counter == PH_MEM);
  assign load_take    = ((state == ST_CAPTURE) || (state == ST_WAIT_MEM)) &&
                        load_lat && mem_rvalid && in_mem_or_wb;
  // Only a genuine 100->000 step retires; a jump to 000 from 011 is an external abort.
  assign commit_exit  = (state == ST_COMMIT) && (phase_counter == PH_FETCH) && phase_was_wb;

  always_comb begin
    capture_data = alu_result;
    case (cls_src_sel)
      SRC_IO:  capture_data = io_in;
      SRC_MEM: capture_data = mem_rdata;
      default: capture_data = alu_result;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      phase_stall  <= 1'b0;
      phase_was_wb <= 1'b0;
    end else begin
      state        <= next_state;
      phase_stall  <= (next_state == ST_WAIT_MEM);
      phase_was_wb <= (phase_counter == PH_WB);
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:     if (phase_counter == PH_MEM) next_state = ST_CAPTURE;
      ST_CAPTURE: begin
        if (!in_mem_or_wb)               next_state = ST_IDLE;
        else if (load_lat && !mem_rvalid) next_state = ST_WAIT_MEM;
        else                             next_state = ST_COMMIT;
      end
      ST_WAIT_MEM: begin
        if (!in_mem_or_wb)   next_state = ST_IDLE;
        else if (mem_rvalid) next_state = ST_COMMIT;
      end
      ST_COMMIT:   if (commit_exit || !in_mem_or_wb) next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    op_reg_write = (state == ST_COMMIT) && wr_lat && (phase_counter == PH_WB);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_for_write       <= '0;
      op_reg_write_address <= 1'b0;
      wr_lat               <= 1'b0;
      upd_lat              <= 1'b0;
      load_lat             <= 1'b0;
      flags_cand           <= 4'b0000;
    end else if (capture_en) begin
      data_for_write       <= capture_data;
      op_reg_write_address <= cls_addr_sel;
      wr_lat               <= cls_writes;
      upd_lat              <= cls_updates_flags;
      load_lat             <= cls_is_load;
      flags_cand           <= alu_flags;
    end else if (load_take) begin
      data_for_write       <= mem_rdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flags <= 4'b0000;
    end else if (commit_exit && upd_lat) begin
      flags <= flags_cand;
    end
  end

`ifdef WB_RETIRE_COUNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retired_count <= '0;
    end else if (commit_exit) begin
      retired_count <= retired_count + 1'b1;
    end
  end
`else
  assign retired_count = '0;
`endif

endmodule

// File: tb/tb_p5_writeback.sv
// Scoreboard bench for p5_writeback: drives full five-phase instruction sequences and
// compares register writes, stalls, flags and the retire counter against expectations.
module tb_p5_writeback;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [2:0]        phase_counter = 3'b000;
  logic [15:0]       ir = 16'h0000;
  logic [DATA_W-1:0] alu_result = '0;
  logic [3:0]        alu_flags = 4'b0000;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_rvalid = 1'b0;
  logic [DATA_W-1:0] io_in = '0;
  logic              op_reg_write;
  logic              op_reg_write_address;
  logic [DATA_W-1:0] data_for_write;
  logic [3:0]        flags;
  logic              phase_stall;
  logic [CNT_W-1:0]  retired_count;

  typedef struct {
    logic [15:0] data;
    logic        addr;
  } wr_exp_t;

  wr_exp_t          sb_q[$];
  int               tests_run = 0;
  int               tests_failed = 0;
  logic [3:0]       flags_exp = 4'b0000;
  logic [CNT_W-1:0] cnt_exp = '0;

  p5_writeback #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .phase_counter             (phase_counter),
    .instruction_register_wire (ir),
    .alu_result                (alu_result),
    .alu_flags                 (alu_flags),
    .mem_rdata                 (mem_rdata),
    .mem_rvalid                (mem_rvalid),
    .io_in                     (io_in),
    .op_reg_write              (op_reg_write),
    .op_reg_write_address      (op_reg_write_address),
    .data_for_write            (data_for_write),
    .flags                     (flags),
    .phase_stall               (phase_stall),
    .retired_count             (retired_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic count_commit;
`ifdef WB_RETIRE_COUNT_EN
    cnt_exp = cnt_exp + 1'b1;
`endif
  endtask

  // late < 0 marks a non-load; otherwise the number of cycles rvalid trails CAPTURE.
  task automatic run_instr(input logic [15:0] i_ir, input logic [15:0] alu, input logic [3:0] af,
                           input logic [15:0] io, input logic [15:0] rdata, input int late,
                           input logic exp_wr, input logic exp_sel, input logic [15:0] exp_data,
                           input logic exp_upd);
    int      stalls;
    wr_exp_t e;
    phase_counter = 3'b000; step;
    phase_counter = 3'b001; step;
    phase_counter = 3'b010; step;
    ir = i_ir; alu_result = alu; alu_flags = af; io_in = io;
    mem_rvalid = (late == 0);
    mem_rdata  = (late == 0) ? rdata : 16'hDEAD;
    if (exp_wr) begin
      e.data = exp_data;
      e.addr = exp_sel;
      sb_q.push_back(e);
    end
    phase_counter = 3'b011; step;
    @(negedge clock);
    if (exp_wr && late < 0) check_eq("early_data", data_for_write, exp_data);
    step;
    mem_rvalid = 1'b0; mem_rdata = 16'hDEAD;
    stalls = 0;
    while (phase_stall === 1'b1 && stalls < 40) begin
      stalls++;
      if (stalls == late) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
      end
      step;
      mem_rvalid = 1'b0; mem_rdata = 16'hDEAD;
    end
    check_eq("stall_cycles", stalls, (late > 0) ? late : 0);
    phase_counter = 3'b100;
    @(negedge clock);
    check_eq("wr_en", op_reg_write, exp_wr);
    if (op_reg_write) begin
      check_eq("sb_pending", sb_q.size(), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_eq("wr_data", data_for_write, e.data);
        check_eq("wr_addr", op_reg_write_address, e.addr);
      end
    end
    step;
    phase_counter = 3'b000; step;
    if (exp_upd) flags_exp = af;
    count_commit();
    check_eq("flags", flags, flags_exp);
    check_eq("retired", retired_count, cnt_exp);
    check_eq("wr_idle", op_reg_write, 1'b0);
  endtask

  initial begin
    alu_result = 16'hFFFF; io_in = 16'hFFFF; mem_rdata = 16'hFFFF; mem_rvalid = 1'b1;
    phase_counter = 3'b011; ir = 16'hC100;
    step; step;
    check_eq("rst_wr", op_reg_write, 1'b0);
    check_eq("rst_addr", op_reg_write_address, 1'b0);
    check_eq("rst_data", data_for_write, 16'h0000);
    check_eq("rst_flags", flags, 4'b0000);
    check_eq("rst_stall", phase_stall, 1'b0);
    check_eq("rst_retired", retired_count, 0);
    mem_rvalid = 1'b0; phase_counter = 3'b000;
    step;
    reset = 1'b1;
    step;

    //        ir        alu       af       io        rdata     late wr sel data      upd
    run_instr(16'hC150, 16'h1111, 4'b0100, 16'h0000, 16'h0000, -1, 0, 0, 16'h0000, 1);
    run_instr(16'hC100, 16'h1234, 4'b0000, 16'h0000, 16'h0000, -1, 1, 0, 16'h1234, 1);
    run_instr(16'hC110, 16'h8001, 4'b1010, 16'h0000, 16'h0000, -1, 1, 0, 16'h8001, 1);
    run_instr(16'hC1C0, 16'h0F0F, 4'b1111, 16'hA5A5, 16'h0000, -1, 1, 0, 16'hA5A5, 0);
    run_instr(16'h8300, 16'h0042, 4'b0101, 16'h0000, 16'h0000, -1, 1, 0, 16'h0042, 0);
    run_instr(16'h0900, 16'h0000, 4'b1111, 16'h0000, 16'hBEEF,  3, 1, 1, 16'hBEEF, 0);
    run_instr(16'h0A00, 16'h0000, 4'b1111, 16'h0000, 16'h1357,  0, 1, 1, 16'h1357, 0);
    run_instr(16'h0100, 16'h0000, 4'b0000, 16'h0000, 16'h2468,  1, 1, 1, 16'h2468, 0);
    run_instr(16'h4000, 16'h7777, 4'b1111, 16'h0000, 16'h0000, -1, 0, 0, 16'h0000, 0);
    run_instr(16'hB800, 16'h7777, 4'b0001, 16'h0000, 16'h0000, -1, 0, 0, 16'h0000, 0);
    run_instr(16'hC1D0, 16'h7777, 4'b0011, 16'h0000, 16'h0000, -1, 0, 0, 16'h0000, 0);
    run_instr(16'hC1F0, 16'h7777, 4'b0111, 16'h0000, 16'h0000, -1, 0, 0, 16'h0000, 0);
    run_instr(16'hC170, 16'h7777, 4'b1001, 16'h0000, 16'h0000, -1, 0, 0, 16'h0000, 0);
    run_instr(16'hC1B0, 16'h00FF, 4'b0110, 16'h0000, 16'h0000, -1, 1, 0, 16'h00FF, 1);

    // Phase counter jumps 011 -> 000 while the result sits in COMMIT: nothing retires.
    phase_counter = 3'b001; step;
    phase_counter = 3'b010; step;
    ir = 16'hC100; alu_result = 16'h7777; alu_flags = 4'b1111;
    phase_counter = 3'b011; step; step;
    phase_counter = 3'b000; step;
    phase_counter = 3'b100;
    @(negedge clock);
    check_eq("abort_wr", op_reg_write, 1'b0);
    step;
    phase_counter = 3'b000; step;
    check_eq("abort_flags", flags, flags_exp);
    check_eq("abort_retired", retired_count, cnt_exp);

    // Reset asserted while waiting on load data.
    phase_counter = 3'b001; step;
    phase_counter = 3'b010; step;
    ir = 16'h0100; mem_rvalid = 1'b0; mem_rdata = 16'hDEAD;
    phase_counter = 3'b011; step; step;
    check_eq("stall_pre_rst", phase_stall, 1'b1);
    step;
    #2 reset = 1'b0;
    #1;
    phase_counter = 3'b000;
    check_eq("mrst_wr", op_reg_write, 1'b0);
    check_eq("mrst_addr", op_reg_write_address, 1'b0);
    check_eq("mrst_data", data_for_write, 16'h0000);
    check_eq("mrst_flags", flags, 4'b0000);
    check_eq("mrst_stall", phase_stall, 1'b0);
    check_eq("mrst_retired", retired_count, 0);
    flags_exp = 4'b0000;
    cnt_exp   = '0;
    step;
    reset = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
    step;
    phase_counter = 3'b001; step;
    mem_rvalid = 1'b0;
    phase_counter = 3'b100;
    @(negedge clock);
    check_eq("post_rst_wr", op_reg_write, 1'b0);
    check_eq("post_rst_data", data_for_write, 16'h0000);
    check_eq("post_rst_stall", phase_stall, 1'b0);
    step;
    phase_counter = 3'b000; step;

    for (int n = 0; n < 16; n++) begin
      run_instr(16'h4000, 16'h0000, 4'b1111, 16'h0000, 16'h0000, -1, 0, 0, 16'h0000, 0);
    end
    check_eq("wrap_retired", retired_count, 0);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
